// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// alu_seq : registered RISC-V ALU; iterative MUL/MULH/DIV/REM built only when
//           ALU_MULDIV_EN is defined.                              Rev 1.0
// ============================================================================
module alu_seq #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [3:0]       ALUCtrl_i,
   input  logic [WIDTH-1:0] data1_i,
   input  logic [WIDTH-1:0] data2_i,
   output logic [WIDTH-1:0] data_o,
   output logic             Zero_o,
   output logic             valid_o
);

   logic [WIDTH-1:0]   data_q;
   logic               valid_q;
   logic [WIDTH:0]     sub_ext;
   logic [SHAMT_W-1:0] shamt;
   logic [WIDTH-1:0]   base_res;

   // Sign-extended subtract: bit WIDTH is the signed less-than flag.
   assign sub_ext = {data1_i[WIDTH-1], data1_i} + ~{data2_i[WIDTH-1], data2_i}
                  + {{WIDTH{1'b0}}, 1'b1};
   assign shamt   = data2_i[SHAMT_W-1:0];

   always_comb begin
      case (ALUCtrl_i)
         4'b0110: base_res = sub_ext[WIDTH-1:0];
         4'b0000: base_res = data1_i & data2_i;
         4'b0001: base_res = data1_i | data2_i;
         4'b0011: base_res = data1_i ^ data2_i;
         4'b1000: base_res = {{(WIDTH-1){1'b0}}, sub_ext[WIDTH]};
         4'b1001: base_res = data1_i << shamt;
         4'b1010: base_res = data1_i >> shamt;
         4'b1011: base_res = $unsigned($signed(data1_i) >>> shamt);
         default: base_res = data1_i + data2_i;
      endcase
   end

   assign data_o  = data_q;
   assign valid_o = valid_q;
   assign Zero_o  = (data_q == '0);

`ifdef ALU_MULDIV_EN
   typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, RUN = 2'd2} state_t;
   localparam logic [SHAMT_W-1:0] c_last_iter = SHAMT_W'(WIDTH - 1);

   state_t             state_q;
   logic               ready_q;
   logic [SHAMT_W-1:0] cnt_q;
   logic [1:0]         op_q;
   logic [WIDTH-1:0]   acc_q, lo_q, opnd_q;
   logic               a_neg_q, b_neg_q, b_zero_q;
   logic [WIDTH-1:0]   acc_d, lo_d, m_res;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH+1:0]   div_diff;
   logic [2*WIDTH-1:0] prod_s;
   logic [WIDTH-1:0]   a_mag, b_mag;

   assign ready_o = ready_q;
   assign a_mag   = lo_q[WIDTH-1]   ? -lo_q   : lo_q;
   assign b_mag   = opnd_q[WIDTH-1] ? -opnd_q : opnd_q;

   // acc holds product-high / partial remainder; lo holds multiplier / quotient.
   always_comb begin
      acc_d    = acc_q;
      lo_d     = lo_q;
      mul_sum  = '0;
      div_diff = '0;
      if (!op_q[1]) begin
         mul_sum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
         acc_d   = mul_sum[WIDTH:1];
         lo_d    = {mul_sum[0], lo_q[WIDTH-1:1]};
      end else begin
         div_diff = {1'b0, acc_q, lo_q[WIDTH-1]} - {2'b00, opnd_q};
         if (div_diff[WIDTH+1]) begin
            acc_d = {acc_q[WIDTH-2:0], lo_q[WIDTH-1]};
            lo_d  = {lo_q[WIDTH-2:0], 1'b0};
         end else begin
            acc_d = div_diff[WIDTH-1:0];
            lo_d  = {lo_q[WIDTH-2:0], 1'b1};
         end
      end
   end

   always_comb begin
      prod_s = (a_neg_q ^ b_neg_q) ? -{acc_d, lo_d} : {acc_d, lo_d};
      case (op_q)
         2'b00:   m_res = prod_s[WIDTH-1:0];
         2'b01:   m_res = prod_s[2*WIDTH-1:WIDTH];
         2'b10:   m_res = b_zero_q ? '1 : ((a_neg_q ^ b_neg_q) ? -lo_d : lo_d);
         default: m_res = a_neg_q ? -acc_d : acc_d;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         ready_q  <= 1'b1;
         valid_q  <= 1'b0;
         data_q   <= '0;
         cnt_q    <= '0;
         op_q     <= 2'b00;
         acc_q    <= '0;
         lo_q     <= '0;
         opnd_q   <= '0;
         a_neg_q  <= 1'b0;
         b_neg_q  <= 1'b0;
         b_zero_q <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (valid_i) begin
                  if (ALUCtrl_i[3:2] == 2'b11) begin
                     state_q <= SETUP;
                     ready_q <= 1'b0;
                     op_q    <= ALUCtrl_i[1:0];
                     lo_q    <= data1_i;
                     opnd_q  <= data2_i;
                  end else begin
                     data_q  <= base_res;
                     valid_q <= 1'b1;
                  end
               end
            end
            SETUP: begin
               a_neg_q  <= lo_q[WIDTH-1];
               b_neg_q  <= opnd_q[WIDTH-1];
               b_zero_q <= (opnd_q == '0);
               lo_q     <= a_mag;
               opnd_q   <= b_mag;
               acc_q    <= '0;
               cnt_q    <= '0;
               state_q  <= RUN;
            end
            RUN: begin
               acc_q <= acc_d;
               lo_q  <= lo_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == c_last_iter) begin
                  data_q  <= m_res;
                  valid_q <= 1'b1;
                  ready_q <= 1'b1;
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
               ready_q <= 1'b1;
            end
         endcase
      end
   end
`else
   assign ready_o = 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_i;
         if (valid_i) begin
            data_q <= base_res;
         end
      end
   end
`endif

endmodule
`default_nettype wire

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered execution unit for the RISC-V datapath. It replaces the single-cycle combinational ALU: the same base operation set, generalised to any power-of-two `WIDTH`. It adds iterative multiply, divide and remainder behind a `valid`/`ready` handshake. Base ops complete in 1 cycle. M-extension ops hold `ready_o` low while they iterate, and the pipeline stalls on `ready_o`.

## Interface
- `WIDTH`, 32, operand/result width; power of two, ≥ 8.
- `SHAMT_W`, `$clog2(WIDTH)`, derived shift-amount width; do not override.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `valid_i`  in  1  operation request.
- `ready_o`  out  1  unit can accept; an op is accepted on an edge where `valid_i && ready_o`.
- `ALUCtrl_i`  in  4  operation code.
- `data1_i`  in  `WIDTH`  operand A, signed.
- `data2_i`  in  `WIDTH`  operand B, signed.
- `data_o`  out  `WIDTH`  registered result; holds until the next result.
- `Zero_o`  out  1  `data_o == 0`, derived from the register.
- `valid_o`  out  1  one-cycle pulse; `data_o` is new in this cycle.

## Operation
- Base op codes:
  - ADD `0010`, SUB `0110`, AND `0000`, OR `0001`, XOR `0011`.
  - SLT `1000`, SLL `1001`, SRL `1010`, SRA `1011`.
  - Any other non-M code executes as ADD.
- SUB/SLT use one `WIDTH+1` sign-extended adder (B inverted, carry-in 1).
  - SLT result = bit `WIDTH` of that sum (signed less-than), zero-extended.
- Shifts use `data2_i[SHAMT_W-1:0]` only. SRA is arithmetic.
- M op codes:
  - MUL `1100`: low `WIDTH` bits of the signed product.
  - MULH `1101`: high `WIDTH` bits of the signed×signed product.
  - DIV `1110`: signed quotient, truncated toward zero.
  - REM `1111`: remainder, taking the sign of the dividend.
- Multiply/divide: magnitudes are taken in a setup cycle, then `WIDTH` iterations run on the magnitudes.
  - Multiply: shift-add.
  - Divide: restoring.
  - Signs are corrected when the result is written.
- Divide special cases:
  - B = 0: DIV = all ones, REM = A.
  - A = most-negative and B = −1: DIV = A, REM = 0.
- FSM states:
  - `IDLE`: `ready_o` = 1.
    - Accepted base op: writes `data_o`, pulses `valid_o`, stays in `IDLE`.
    - Accepted M op: goes to `SETUP`.
  - `SETUP`: to `RUN`; iteration counter cleared.
  - `RUN`: counter increments each cycle. After `WIDTH` iterations, writes `data_o`, pulses `valid_o`, returns to `IDLE`.
- `valid_i` is ignored whenever `ready_o` = 0. Operands are latched at accept, so inputs may change afterwards.

## Timing
- Reset values: `data_o` = 0, `Zero_o` = 1, `valid_o` = 0, `ready_o` = 1, state `IDLE`, counter 0.
- Base op latency is 1 cycle. Back-to-back base ops run at 1 per cycle.
- M op latency is `WIDTH+1` cycles.
  - `ready_o` is low for the `WIDTH+1` cycles after the accept edge.
  - `valid_o` pulses in the cycle `ready_o` returns high.
  - A new op may be accepted in that same cycle.
- `rst_n` asserted mid-operation aborts immediately: no `valid_o`, all outputs at their reset values.

## Configuration
- `ALU_MULDIV_EN` defined: M ops behave as specified above.
- `ALU_MULDIV_EN` undefined:
  - Multiply/divide datapath and `SETUP`/`RUN` states are not built.
  - Codes `11xx` execute as ADD with 1-cycle latency.
  - `ready_o` is tied to 1 after reset.

## Test plan
All scenarios use `WIDTH` = 32.
- Base ADD/SUB:
  - ADD `0x7FFFFFFF` + 1 → `data_o` = `0x80000000` next cycle, `valid_o` high exactly 1 cycle.
  - SUB 5 − 5 → `data_o` = 0, `Zero_o` = 1.
- SLT and shifts:
  - SLT −1, 1 → 1; SLT 1, −1 → 0.
  - SRA `0x80000000` by 4 → `0xF8000000`.
  - SLL 1 by 33 → 2 (only 5 LSBs of the shift amount used).
- Multiply:
  - MUL −1 × 3 → `0xFFFFFFFD`.
  - MULH −1 × 3 → `0xFFFFFFFF`.
  - `ready_o` low exactly 33 cycles; `valid_o` 33 cycles after accept; `valid_i` pulses while busy are ignored.
- Divide:
  - DIV −7 / 2 → `0xFFFFFFFD`; REM → `0xFFFFFFFF`.
  - DIV 9 / 0 → `0xFFFFFFFF`; REM 9 / 0 → 9.
  - DIV `0x80000000` / −1 → `0x80000000`; REM → 0.
- Reset mid-operation: `rst_n` low at iteration 10 of a DIV → `ready_o` = 1, `data_o` = 0, `valid_o` never pulses; the next ADD 3 + 4 → 7.
- `ALU_MULDIV_EN` undefined: code `1100` with 3, 4 → 7 after 1 cycle, `ready_o` constantly 1.
